// File: rtl/uart_prog_loader_ctrl_pkg.sv
// Shared command opcodes and controller state encodings for the UART program loader.
package uart_prog_loader_ctrl_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;
    localparam logic [7:0] CMD_STEP = 8'h04;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

endpackage

// File: rtl/uart_prog_loader_ctrl_valid_edge_detect.sv
// Turns the receiver's word-ready level into a single accept per rising edge.
module valid_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    output logic acc_o
);

    logic vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= valid_i;
        end
    end

    assign acc_o = valid_i & ~vld_q;

endmodule

// File: rtl/uart_prog_loader_ctrl.sv
// Boot controller: decodes UART command words, sequences core reset/enable
// and streams instruction words into IMEM at consecutive addresses.
module uart_prog_loader_ctrl
    import uart_prog_loader_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_word,
    input  logic              in_valid,
    input  logic              in_is_cmd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W:0]   CAP      = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

    logic              acc_d;
    logic              acc_q;
    logic              is_cmd_q;
    logic [31:0]       word_q;
    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_rst_q;
    logic              cpu_en_q;
    logic              overflow_q;

    valid_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .valid_i (in_valid),
        .acc_o   (acc_d)
    );

    // The accepted word is captured first, so the FSM acts one edge after the accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= 1'b0;
            is_cmd_q <= 1'b0;
            word_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (acc_d) begin
                is_cmd_q <= in_is_cmd;
                word_q   <= in_word;
            end
        end
    end

    logic cmd_acc;
    logic data_acc;
    logic go_load;
    logic go_run;
    logic go_halt;
    logic go_step;

    assign cmd_acc  = acc_q & is_cmd_q;
    assign data_acc = acc_q & ~is_cmd_q;
    assign go_load  = cmd_acc & (word_q[7:0] == CMD_LOAD);
    assign go_run   = cmd_acc & (word_q[7:0] == CMD_RUN);
    assign go_halt  = cmd_acc & (word_q[7:0] == CMD_HALT);
    assign go_step  = cmd_acc & (word_q[7:0] == CMD_STEP);

    // LOAD/RUN/HALT have the same effect from every state; STEP is honoured only
    // from HALT, and the STEP cycle itself behaves as HALT so nothing is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HALT;
            ptr_q        <= BASE_PTR;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_PTR;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_en_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (go_load) begin
                state_q    <= ST_LOAD;
                cpu_rst_q  <= 1'b1;
                cpu_en_q   <= 1'b0;
                ptr_q      <= BASE_PTR;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (go_run) begin
                state_q   <= ST_RUN;
                cpu_rst_q <= 1'b0;
                cpu_en_q  <= 1'b1;
            end else if (go_halt) begin
                state_q  <= ST_HALT;
                cpu_en_q <= 1'b0;
            end else if (go_step && (state_q == ST_HALT || state_q == ST_STEP)) begin
                state_q   <= ST_STEP;
                cpu_rst_q <= 1'b0;
                cpu_en_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_STEP: begin
                        state_q  <= ST_HALT;
                        cpu_en_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (data_acc) begin
                            if (count_q == CAP) begin
                                overflow_q <= 1'b1;
                            end else begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= ptr_q;
                                imem_wdata_q <= word_q;
                                ptr_q        <= ptr_q + 1'b1;
                                count_q      <= count_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_en     = cpu_en_q;
    assign load_count = count_q;
    assign overflow   = overflow_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_uart_prog_loader_ctrl.sv
// Directed bench for uart_prog_loader_ctrl: a default-size instance and an
// ADDR_W=2 instance share the same UART stimulus.
module tb_uart_prog_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_is_cmd = 1'b0;

    logic        imem_we, cpu_rst, cpu_en, overflow;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] load_count;
    logic [1:0]  state_o;

    logic        s_imem_we, s_cpu_rst, s_cpu_en, s_overflow;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [2:0]  s_load_count;
    logic [1:0]  s_state_o;

    int pass_cnt = 0;
    int total    = 0;
    int we_cnt   = 0;
    int s_we_cnt = 0;
    int en_cnt   = 0;
    int trans_cnt = 0;
    logic [1:0] prev_state = 2'd0;

    uart_prog_loader_ctrl dut (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_is_cmd(in_is_cmd), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
        .load_count(load_count), .overflow(overflow), .state_o(state_o)
    );

    uart_prog_loader_ctrl #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_is_cmd(in_is_cmd), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .cpu_rst(s_cpu_rst), .cpu_en(s_cpu_en),
        .load_count(s_load_count), .overflow(s_overflow), .state_o(s_state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we)   we_cnt   <= we_cnt + 1;
        if (s_imem_we) s_we_cnt <= s_we_cnt + 1;
        if (cpu_en)    en_cnt   <= en_cnt + 1;
        if (state_o != prev_state) trans_cnt <= trans_cnt + 1;
        prev_state <= state_o;
    end

    // Called at a negedge; returns at the negedge where the word's effect is visible.
    task automatic send(input logic [31:0] w, input logic c, input int hold);
        in_word   = w;
        in_is_cmd = c;
        in_valid  = 1'b1;
        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        total++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else pass_cnt++;
        total++; if (cpu_rst !== 1'b1) $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
        total++; if (cpu_en !== 1'b0) $display("FAIL rst_cpu_en: got %b want 0", cpu_en); else pass_cnt++;
        total++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0)
            $display("FAIL rst_imem: got we=%b addr=%0d data=%h want 0/0/0", imem_we, imem_addr, imem_wdata); else pass_cnt++;
        total++; if (load_count !== 11'd0 || overflow !== 1'b0)
            $display("FAIL rst_count: got cnt=%0d ovf=%b want 0/0", load_count, overflow); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (state_o !== 2'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0)
            $display("FAIL rel_state: got st=%0d rst=%b en=%b want 0/1/0", state_o, cpu_rst, cpu_en); else pass_cnt++;
    endtask

    task automatic test_held_valid;
        int w0;
        trans_cnt = 0;
        send(32'h0000_0001, 1'b1, 3);
        @(negedge clk);
        total++; if (state_o !== 2'd1) $display("FAIL held_load_state: got %0d want 1", state_o); else pass_cnt++;
        total++; if (trans_cnt !== 1) $display("FAIL held_load_trans: got %0d want 1", trans_cnt); else pass_cnt++;
        w0 = we_cnt;
        send(32'h1234_5678, 1'b0, 3);
        @(negedge clk);
        total++; if (load_count !== 11'd1) $display("FAIL held_data_count: got %0d want 1", load_count); else pass_cnt++;
        total++; if (we_cnt - w0 !== 1) $display("FAIL held_data_we: got %0d want 1", we_cnt - w0); else pass_cnt++;
    endtask

    task automatic test_load;
        send(32'h0000_0001, 1'b1, 1);
        total++; if (state_o !== 2'd1 || load_count !== 11'd0)
            $display("FAIL load_entry: got st=%0d cnt=%0d want 1/0", state_o, load_count); else pass_cnt++;
        send(32'h0050_0093, 1'b0, 1);
        total++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h0050_0093)
            $display("FAIL load_w0: got we=%b addr=%0d data=%h want 1/0/00500093", imem_we, imem_addr, imem_wdata); else pass_cnt++;
        @(negedge clk);
        total++; if (imem_we !== 1'b0) $display("FAIL load_we_drop: got %b want 0", imem_we); else pass_cnt++;
        send(32'h0010_0113, 1'b0, 1);
        total++; if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wdata !== 32'h0010_0113)
            $display("FAIL load_w1: got we=%b addr=%0d data=%h want 1/1/00100113", imem_we, imem_addr, imem_wdata); else pass_cnt++;
        send(32'h0000_0003, 1'b1, 1);
        total++; if (state_o !== 2'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0 || load_count !== 11'd2)
            $display("FAIL load_halt: got st=%0d rst=%b en=%b cnt=%0d want 0/1/0/2", state_o, cpu_rst, cpu_en, load_count); else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        send(32'h0000_0001, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            d = 32'hA000_0000 + 32'(i);
            send(d, 1'b0, 1);
            if (i < 4) begin
                total++; if (s_imem_we !== 1'b1 || s_imem_addr !== 2'(i) || s_imem_wdata !== d)
                    $display("FAIL ovf_w%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, s_imem_we, s_imem_addr, s_imem_wdata, i, d); else pass_cnt++;
            end else begin
                total++; if (s_imem_we !== 1'b0 || s_overflow !== 1'b1)
                    $display("FAIL ovf_drop: got we=%b ovf=%b want 0/1", s_imem_we, s_overflow); else pass_cnt++;
            end
        end
        total++; if (s_load_count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", s_load_count); else pass_cnt++;
        total++; if (overflow !== 1'b0 || load_count !== 11'd5)
            $display("FAIL big_no_ovf: got ovf=%b cnt=%0d want 0/5", overflow, load_count); else pass_cnt++;
        send(32'h0000_0001, 1'b1, 1);
        total++; if (s_overflow !== 1'b0 || s_load_count !== 3'd0)
            $display("FAIL ovf_clear: got ovf=%b cnt=%0d want 0/0", s_overflow, s_load_count); else pass_cnt++;
        send(32'h0000_0003, 1'b1, 1);
    endtask

    task automatic test_step;
        total++; if (cpu_rst !== 1'b1 || state_o !== 2'd0)
            $display("FAIL step_pre: got rst=%b st=%0d want 1/0", cpu_rst, state_o); else pass_cnt++;
        en_cnt = 0;
        send(32'h0000_0004, 1'b1, 1);
        total++; if (state_o !== 2'd3 || cpu_en !== 1'b1 || cpu_rst !== 1'b0)
            $display("FAIL step_active: got st=%0d en=%b rst=%b want 3/1/0", state_o, cpu_en, cpu_rst); else pass_cnt++;
        repeat (3) @(negedge clk);
        total++; if (state_o !== 2'd0 || cpu_en !== 1'b0 || cpu_rst !== 1'b0)
            $display("FAIL step_after: got st=%0d en=%b rst=%b want 0/0/0", state_o, cpu_en, cpu_rst); else pass_cnt++;
        total++; if (en_cnt !== 1) $display("FAIL step_en_cycles: got %0d want 1", en_cnt); else pass_cnt++;
    endtask

    task automatic test_run;
        int w0;
        send(32'h0000_0002, 1'b1, 1);
        total++; if (state_o !== 2'd2 || cpu_en !== 1'b1 || cpu_rst !== 1'b0)
            $display("FAIL run_entry: got st=%0d en=%b rst=%b want 2/1/0", state_o, cpu_en, cpu_rst); else pass_cnt++;
        w0 = we_cnt;
        send(32'hDEAD_BEEF, 1'b0, 1);
        @(negedge clk);
        total++; if (we_cnt !== w0 || state_o !== 2'd2)
            $display("FAIL run_data: got we_pulses=%0d st=%0d want 0/2", we_cnt - w0, state_o); else pass_cnt++;
        send(32'h0000_007F, 1'b1, 1);
        total++; if (state_o !== 2'd2 || cpu_en !== 1'b1)
            $display("FAIL run_badop: got st=%0d en=%b want 2/1", state_o, cpu_en); else pass_cnt++;
        send(32'h0000_0003, 1'b1, 1);
        total++; if (state_o !== 2'd0 || cpu_en !== 1'b0)
            $display("FAIL run_halt: got st=%0d en=%b want 0/0", state_o, cpu_en); else pass_cnt++;
    endtask

    task automatic test_reset_midload;
        int w0;
        send(32'h0000_0001, 1'b1, 1);
        w0 = we_cnt;
        in_word   = 32'hCAFE_F00D;
        in_is_cmd = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        total++; if (imem_we !== 1'b0 || state_o !== 2'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0 ||
                     load_count !== 11'd0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0)
            $display("FAIL midrst_async: got we=%b st=%0d rst=%b en=%b cnt=%0d addr=%0d data=%h want reset values",
                     imem_we, state_o, cpu_rst, cpu_en, load_count, imem_addr, imem_wdata); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (we_cnt !== w0 || state_o !== 2'd0)
            $display("FAIL midrst_no_we: got pulses=%0d st=%0d want 0/0", we_cnt - w0, state_o); else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_held_valid;
        test_load;
        test_overflow;
        test_step;
        test_run;
        test_reset_midload;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
